// File: rtl/disp_mux_n.sv
// disp_mux_n: time-multiplexed N-digit seven-segment display driver.
//
// A free-running prescaler of 2^DIV_W clocks defines one digit slot. At the end of
// each slot the digit index advances, and it wraps NDIG-1 -> 0 at each frame
// boundary. Frame data is double-buffered. A load writes the pending buffer. At
// a frame boundary the pending frame becomes the active frame that the display
// reads. The first GUARD clocks of every slot are blanked to stop ghosting.
//
// Optional feature: define DISP_MUX_PWM_EN to add the brightness port. This
// enables per-slot duty gating using the top four prescaler bits.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high reset
//   seg_in     - segment patterns, digit k = seg_in[8k+7:8k]
//   blank_in   - per-digit blank request (1 = dark)
//   load       - single-cycle strobe capturing seg_in/blank_in as the next frame
//   brightness - duty level 0..15 (DISP_MUX_PWM_EN builds only)
//   an         - digit enables, active low, at most one low
//   sseg       - segment pattern of the enabled digit, 8'hFF when none
//   load_ack   - one-cycle pulse when a captured frame becomes active
//   frame_tick - one-cycle pulse when the digit index wraps to 0
module disp_mux_n #(
    parameter int unsigned NDIG  = 4,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned GUARD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8*NDIG-1:0] seg_in,
    input  logic [NDIG-1:0]   blank_in,
    input  logic              load,
`ifdef DISP_MUX_PWM_EN
    input  logic [3:0]        brightness,
`endif
    output logic [NDIG-1:0]   an,
    output logic [7:0]        sseg,
    output logic              load_ack,
    output logic              frame_tick
);

    localparam int unsigned IDX_W = $clog2(NDIG);

    logic [DIV_W-1:0]      presc_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  pend_q;
    logic [NDIG-1:0][7:0]  pend_seg_q;
    logic [NDIG-1:0]       pend_blank_q;
    logic [NDIG-1:0][7:0]  act_seg_q;
    logic [NDIG-1:0]       act_blank_q;

    logic       presc_wrap;
    logic       last_digit;
    logic       frame_end;
    logic       past_guard;
    logic       duty_ok;
    logic       digit_en;
    logic [7:0] cur_seg;
    logic       cur_blank;

    assign presc_wrap = (presc_q == {DIV_W{1'b1}});
    assign last_digit = (idx_q == IDX_W'(NDIG - 1));
    assign frame_end  = presc_wrap && last_digit;

    generate
        if (GUARD == 0) begin : g_no_guard
            assign past_guard = 1'b1;
        end else begin : g_guard
            assign past_guard = (presc_q >= DIV_W'(GUARD));
        end
    endgenerate

`ifdef DISP_MUX_PWM_EN
    assign duty_ok = (presc_q[DIV_W-1 -: 4] < brightness);
`else
    assign duty_ok = 1'b1;
`endif

    // Compare loop avoids indexing past NDIG-1 when NDIG is not a power of two.
    always_comb begin
        cur_seg   = 8'hFF;
        cur_blank = 1'b1;
        for (int k = 0; k < int'(NDIG); k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_seg   = act_seg_q[k];
                cur_blank = act_blank_q[k];
            end
        end
    end

    assign digit_en = past_guard && duty_ok && !cur_blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            pend_seg_q   <= '0;
            pend_blank_q <= '0;
            act_seg_q    <= {NDIG{8'hFF}};
            act_blank_q  <= {NDIG{1'b1}};
            an           <= {NDIG{1'b1}};
            sseg         <= 8'hFF;
            load_ack     <= 1'b0;
            frame_tick   <= 1'b0;
        end else begin
            presc_q    <= presc_q + 1'b1;
            frame_tick <= frame_end;
            load_ack   <= 1'b0;

            if (presc_wrap) begin
                idx_q <= last_digit ? '0 : idx_q + 1'b1;
            end

            if (frame_end) begin
                // A load on the boundary cycle is newer than the pending frame.
                if (load) begin
                    act_seg_q   <= seg_in;
                    act_blank_q <= blank_in;
                    pend_q      <= 1'b0;
                    load_ack    <= 1'b1;
                end else if (pend_q) begin
                    act_seg_q   <= pend_seg_q;
                    act_blank_q <= pend_blank_q;
                    pend_q      <= 1'b0;
                    load_ack    <= 1'b1;
                end
            end else if (load) begin
                pend_seg_q   <= seg_in;
                pend_blank_q <= blank_in;
                pend_q       <= 1'b1;
            end

            // Outputs are built from the pre-edge index/prescaler/active frame.
            if (digit_en) begin
                an   <= ~(NDIG'(1) << idx_q);
                sseg <= cur_seg;
            end else begin
                an   <= {NDIG{1'b1}};
                sseg <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_disp_mux_n.sv
module tb_disp_mux_n;

    localparam int NDIG  = 3;
    localparam int DIV_W = 4;
    localparam int GUARD = 2;
    localparam int SLOT  = 1 << DIV_W;
    localparam int FRAME = SLOT * NDIG;

    logic              clk = 1'b0;
    logic              reset;
    logic [8*NDIG-1:0] seg_in;
    logic [NDIG-1:0]   blank_in;
    logic              load;
    logic [3:0]        brightness;
    logic [NDIG-1:0]   an;
    logic [7:0]        sseg;
    logic              load_ack;
    logic              frame_tick;

    disp_mux_n #(
        .NDIG  (NDIG),
        .DIV_W (DIV_W),
        .GUARD (GUARD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .blank_in   (blank_in),
        .load       (load),
`ifdef DISP_MUX_PWM_EN
        .brightness (brightness),
`endif
        .an         (an),
        .sseg       (sseg),
        .load_ack   (load_ack),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int n_acks   = 0;

    // Reference model: time since reset release plus the visible frame and the
    // most recent load not yet shown.
    int                m_n;
    logic [8*NDIG-1:0] m_act_seg;
    logic [NDIG-1:0]   m_act_blank;
    logic [8*NDIG-1:0] m_new_seg;
    logic [NDIG-1:0]   m_new_blank;
    bit                m_have_new;
    logic [NDIG-1:0]   e_an;
    logic [7:0]        e_sseg;
    logic              e_ack;
    logic              e_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s at t=%0t (model n=%0d): got %0h expected %0h", tag, $time, m_n,
                     obs, exp);
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge), advance the
    // model across the rising edge, then compare on the next falling edge.
    task automatic step(input bit r, input bit ld, input logic [8*NDIG-1:0] s,
                        input logic [NDIG-1:0] b, input logic [3:0] br);
        int  idx;
        int  p;
        bit  on;
        reset      = r;
        load       = ld;
        seg_in     = s;
        blank_in   = b;
        brightness = br;
        if (r) begin
            m_n         = 0;
            m_act_seg   = {NDIG{8'hFF}};
            m_act_blank = '1;
            m_have_new  = 0;
            e_an        = '1;
            e_sseg      = 8'hFF;
            e_ack       = 0;
            e_tick      = 0;
        end else begin
            idx = (m_n / SLOT) % NDIG;
            p   = m_n % SLOT;
            on  = (p >= GUARD) && !m_act_blank[idx];
`ifdef DISP_MUX_PWM_EN
            on  = on && ((p >> (DIV_W - 4)) < int'(br));
`endif
            e_an   = on ? ~(NDIG'(1) << idx) : '1;
            e_sseg = on ? m_act_seg[8*idx +: 8] : 8'hFF;
            if (ld) begin
                m_new_seg   = s;
                m_new_blank = b;
                m_have_new  = 1;
            end
            e_tick = ((m_n + 1) % FRAME == 0);
            e_ack  = e_tick && m_have_new;
            if (e_ack) begin
                m_act_seg   = m_new_seg;
                m_act_blank = m_new_blank;
            end
            if (e_tick) m_have_new = 0;
            m_n++;
        end
        @(posedge clk);
        @(negedge clk);
        check("an", 32'(an), 32'(e_an));
        check("sseg", 32'(sseg), 32'(e_sseg));
        check("load_ack", 32'(load_ack), 32'(e_ack));
        check("frame_tick", 32'(frame_tick), 32'(e_tick));
        if (load_ack === 1'b1) n_acks++;
    endtask

    logic [3:0] cur_br;

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, '0, '0, cur_br);
    endtask

    // Run idle until the next cycle is the last one of a frame.
    task automatic to_boundary();
        int guard_cnt = 0;
        while ((m_n + 1) % FRAME != 0 && guard_cnt < 2 * FRAME) begin
            step(0, 0, '0, '0, cur_br);
            guard_cnt++;
        end
    endtask

    initial begin
        int acks0;
        logic [8*NDIG-1:0] rs;
        logic [NDIG-1:0]   rb;
        cur_br = 4'd15;
        @(negedge clk);
        step(1, 1, 24'h123456, '0, cur_br);  // load during reset is discarded
        step(1, 0, '0, '0, cur_br);

        // Idle after reset: dark, frame_tick every FRAME clocks.
        idle(200);

        // Mid-frame load shows up only at the next boundary.
        idle(7);
        step(0, 1, {8'h03, 8'h02, 8'h01}, 3'b000, cur_br);
        idle(2 * FRAME);

        // Two loads in one frame: only the second is shown, one ack.
        to_boundary();
        idle(5);
        acks0 = n_acks;
        step(0, 1, {3{8'hAA}}, 3'b000, cur_br);
        idle(10);
        step(0, 1, {3{8'h55}}, 3'b000, cur_br);
        idle(FRAME);
        check("single_ack", 32'(n_acks - acks0), 32'd1);

        // Load exactly on the boundary cycle bypasses the pending buffer.
        to_boundary();
        step(0, 1, {8'h33, 8'h22, 8'h7E}, 3'b000, cur_br);
        idle(FRAME);

        // Blank the middle digit.
        step(0, 1, {8'h0C, 8'h0B, 8'h0A}, 3'b010, cur_br);
        idle(2 * FRAME);

`ifdef DISP_MUX_PWM_EN
        cur_br = 4'd4;
        idle(FRAME);
        cur_br = 4'd0;
        idle(FRAME);
        cur_br = 4'd15;
`endif

        // Reset with a frame pending: no ack, back to reset state.
        idle(3);
        step(0, 1, {3{8'h11}}, 3'b000, cur_br);
        idle(4);
        acks0 = n_acks;
        step(1, 0, '0, '0, cur_br);
        idle(FRAME + 5);
        check("no_ack_after_reset", 32'(n_acks - acks0), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            rs = {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? NDIG'($urandom) : '0;
            if ($urandom_range(0, 199) == 0) cur_br = 4'($urandom);
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) == 0), rs, rb, cur_br);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/disp_mux_n.md
DISP_MUX_N -- requirements
Module: disp_mux_n

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of digits (legal 2..8, power of two not required).
REQ-002 SHALL have parameter DIV_W, default 16, refresh prescaler width; slot length 2^DIV_W clocks (legal 4..24).
REQ-003 SHALL have parameter GUARD, default 2, anti-ghost blank clocks at start of each slot (legal 0..2^DIV_W-1).
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 seg_in  input  8*NDIG  segment patterns; digit k = seg_in[8k+7:8k].
REQ-007 blank_in  input  NDIG  per-digit blank request, 1 = digit dark.
REQ-008 load  input  1  single-cycle strobe; captures seg_in/blank_in as the next frame.
REQ-009 brightness  input  4  duty level; present only with DISP_MUX_PWM_EN.
REQ-010 an  output  NDIG  digit enables, active low, at most one low.
REQ-011 sseg  output  8  segment pattern of the enabled digit; 8'hFF when no digit enabled.
REQ-012 load_ack  output  1  one-cycle pulse when a captured frame becomes active.
REQ-013 frame_tick  output  1  one-cycle pulse when the digit index wraps NDIG-1 -> 0.

Function
REQ-014 Prescaler SHALL count 0..2^DIV_W-1 and wrap; on wrap, digit index SHALL advance by 1, wrapping NDIG-1 -> 0.
REQ-015 frame_tick SHALL assert on the same cycle the index register takes value 0 after NDIG-1.
REQ-016 Frame data SHALL be double-buffered: pending buffer + active buffer; display reads only the active buffer.
REQ-017 load=1 SHALL write pending buffer and set pend flag; repeated load before transfer: last write wins, no ack for overwritten frames.
REQ-018 At frame boundary with pend=1, active <= pending, pend cleared, load_ack pulses same cycle as frame_tick.
REQ-019 load coincident with frame boundary SHALL bypass: active <= seg_in/blank_in directly, pend cleared, load_ack pulses.
REQ-020 Frame boundary with pend=0 SHALL leave active unchanged, no load_ack.
REQ-021 an/sseg SHALL be registered: outputs reflect index and prescaler one clock later.
REQ-022 Digit k enabled (an[k]=0, sseg=active[k]) only when index=k, prescaler>=GUARD, and active blank[k]=0; otherwise an all ones, sseg=8'hFF.
REQ-023 GUARD=0 SHALL enable the digit for the whole slot.

Reset
REQ-024 On reset: prescaler 0, index 0, pend 0, active seg all 8'hFF, active blank all 1, pending cleared, an all ones, sseg 8'hFF, load_ack 0, frame_tick 0.
REQ-025 Reset SHALL dominate load on the same cycle; load during reset discarded.
REQ-026 Reset mid-frame SHALL abandon any pending frame with no load_ack.

Configuration
REQ-027 Macro DISP_MUX_PWM_EN defined: brightness port exists; digit additionally enabled only while prescaler[DIV_W-1:DIV_W-4] < brightness; brightness=0 -> always dark, 15 -> 15/16 of slot; GUARD still applies.
REQ-028 DISP_MUX_PWM_EN undefined: no brightness port, no duty gating, behaviour per REQ-022 only.

Verification (NDIG=3, DIV_W=4, GUARD=2)
REQ-029 Release reset, no load -> an=3'b111, sseg=8'hFF for 200 clocks; frame_tick every 48 clocks.
REQ-030 load seg_in={8'h03,8'h02,8'h01}, blank_in=0 mid-frame -> no change until frame_tick, load_ack with it; then digit0 sseg=8'h01 for prescaler 2..15 (an=3'b110), digits 1,2 follow; an=3'b111 for guard clocks.
REQ-031 Two loads (8'hAA.., 8'h55..) within one frame -> only 8'h55 pattern displayed, exactly one load_ack.
REQ-032 load on frame-boundary cycle with seg_in digit0=8'h7E -> load_ack that cycle, digit0 shows 8'h7E in the slot starting then.
REQ-033 blank_in=3'b010 loaded -> digit1 slot shows an=3'b111, sseg=8'hFF; digits 0,2 normal.
REQ-034 PWM build, brightness=4 -> each digit on for prescaler 2..3 only; brightness=0 -> an all ones; reset mid-frame with pend=1 -> no load_ack, outputs per REQ-024.
